// File: rtl/proc_controller_if.sv
// Control bus between proc_controller and the instruction ROM / register-file / ALU / data-memory datapath.
// The controller takes the master modport; the datapath-and-memory side takes the slave modport.
interface proc_controller_if #(
    parameter int PC_W = 7
);
    logic [15:0]     IData;
    logic [PC_W-1:0] IAddr;
    logic [7:0]      DAddr;
    logic            DWrite;
    logic            RFSelect;
    logic [3:0]      WriteAddr;
    logic            RFWriteEnable;
    logic [3:0]      ReadAddrA;
    logic [3:0]      ReadAddrB;
    logic [2:0]      ALUSelect;
    logic [PC_W-1:0] PCOut;
    logic [15:0]     IROut;
    logic [3:0]      StateOut;
    logic            Halted;

    modport master (
        input  IData,
        output IAddr, DAddr, DWrite, RFSelect, WriteAddr, RFWriteEnable,
               ReadAddrA, ReadAddrB, ALUSelect, PCOut, IROut, StateOut, Halted
    );

    modport slave (
        output IData,
        input  IAddr, DAddr, DWrite, RFSelect, WriteAddr, RFWriteEnable,
               ReadAddrA, ReadAddrB, ALUSelect, PCOut, IROut, StateOut, Halted
    );
endinterface

// File: rtl/proc_controller.sv
// Multi-cycle control unit: owns PC and IR, fetches from a registered-address ROM,
// decodes, and drives every datapath control input as a function of state and IR.
module proc_controller #(
    parameter int         PC_W    = 7,
    parameter logic [2:0] ALU_ADD = 3'b001,
    parameter logic [2:0] ALU_SUB = 3'b010
) (
    input  logic              Clk,
    input  logic              Reset,
    proc_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        ir_d              = ir_q;
        bus.DWrite        = 1'b0;
        bus.RFWriteEnable = 1'b0;
        bus.RFSelect      = 1'b0;
        bus.ALUSelect     = 3'b000;
        bus.DAddr         = 8'h00;
        bus.WriteAddr     = 4'h0;
        bus.ReadAddrA     = 4'h0;
        bus.ReadAddrB     = 4'h0;

        unique case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.IData;
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_NOOP: state_d = S_FETCH;
            // LOAD_A only presents the address; memory data is valid in LOAD_B.
            S_LOAD_A: begin
                bus.DAddr     = ir_q[7:0];
                bus.RFSelect  = 1'b1;
                bus.WriteAddr = ir_q[11:8];
                state_d       = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.DAddr         = ir_q[7:0];
                bus.RFSelect      = 1'b1;
                bus.WriteAddr     = ir_q[11:8];
                bus.RFWriteEnable = 1'b1;
                state_d           = S_FETCH;
            end
            S_STORE: begin
                bus.DAddr     = ir_q[7:0];
                bus.ReadAddrA = ir_q[11:8];
                bus.DWrite    = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADD, S_SUB: begin
                bus.ReadAddrA     = ir_q[11:8];
                bus.ReadAddrB     = ir_q[7:4];
                bus.WriteAddr     = ir_q[3:0];
                bus.RFWriteEnable = 1'b1;
                bus.ALUSelect     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
                state_d           = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    assign bus.IAddr    = pc_q;
    assign bus.PCOut    = pc_q;
    assign bus.IROut    = ir_q;
    assign bus.StateOut = state_q;
    assign bus.Halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_proc_controller.sv
// Directed bench for proc_controller with a registered-address ROM, a 16x16 register file,
// an ALU and a one-cycle-latency data memory modelled around it.
module tb_proc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_controller_if #(.PC_W(7)) bus ();

    proc_controller #(.PC_W(7)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rom   [128];
    logic [15:0] dinit [256];
    logic [15:0] dmem  [256];
    logic [15:0] rf    [16];
    logic [15:0] dq;
    logic        clear_req = 1'b0;

    logic [15:0] rfa, rfb, alu_q;
    assign rfa   = rf[bus.ReadAddrA];
    assign rfb   = rf[bus.ReadAddrB];
    assign alu_q = (bus.ALUSelect == 3'b001) ? rfa + rfb :
                   (bus.ALUSelect == 3'b010) ? rfa - rfb : 16'h0000;

    // Environment: ROM and data memory both register their address; RF reads are combinational.
    always @(posedge clk) begin
        bus.IData <= rom[bus.IAddr];
        dq        <= dmem[bus.DAddr];
        if (clear_req) begin
            for (int i = 0; i < 16; i++)  rf[i]   <= 16'h0000;
            for (int i = 0; i < 256; i++) dmem[i] <= dinit[i];
        end else begin
            if (bus.DWrite)        dmem[bus.DAddr]    <= rfa;
            if (bus.RFWriteEnable) rf[bus.WriteAddr]  <= bus.RFSelect ? dq : alu_q;
        end
    end

    // Observation of per-state drives while a program runs.
    logic       store_seen;
    logic [7:0] store_daddr;
    logic [3:0] store_ra;
    logic [2:0] add_alu, sub_alu;
    int         overlap_cnt;
    always @(negedge clk) begin
        if (clear_req) begin
            store_seen  <= 1'b0;
            store_daddr <= 8'h00;
            store_ra    <= 4'h0;
            add_alu     <= 3'b000;
            sub_alu     <= 3'b000;
            overlap_cnt <= 0;
        end else begin
            if (bus.DWrite && bus.RFWriteEnable) overlap_cnt <= overlap_cnt + 1;
            if (bus.StateOut == 4'd6) begin
                store_seen  <= bus.DWrite;
                store_daddr <= bus.DAddr;
                store_ra    <= bus.ReadAddrA;
            end
            if (bus.StateOut == 4'd7) add_alu <= bus.ALUSelect;
            if (bus.StateOut == 4'd8) sub_alu <= bus.ALUSelect;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
        for (int i = 0; i < 256; i++) dinit[i] = 16'h0000;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        clear_req = 1'b1;
        repeat (n) step();
        clear_req = 1'b0;
    endtask

    task automatic load_program(input logic [15:0] a, input logic [15:0] b);
        fill_rom(16'h5000);
        rom[0] = 16'h2000;
        rom[1] = 16'h2101;
        rom[2] = 16'h3012;
        rom[3] = 16'h4013;
        rom[4] = 16'h1209;
        rom[5] = 16'h5000;
        dinit[0] = a;
        dinit[1] = b;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        while (!bus.Halted && cycles < 200) begin
            step();
            cycles++;
        end
        n_checks++;
        if (bus.Halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_timeout: Halted=%b after %0d cycles, required 1", bus.Halted, cycles);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_st [4] = '{4'd1, 4'd2, 4'd3, 4'd1};
        fill_rom(16'h0000);
        apply_reset(2);
        n_checks++; if (bus.StateOut !== 4'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.StateOut); end
        n_checks++; if (bus.PCOut !== 7'd0 || bus.IAddr !== 7'd0) begin n_fail++; $display("FAIL rst_pc: PC=%0d IAddr=%0d want 0", bus.PCOut, bus.IAddr); end
        n_checks++; if (bus.IROut !== 16'h0000) begin n_fail++; $display("FAIL rst_ir: got %h want 0000", bus.IROut); end
        n_checks++;
        if ({bus.DWrite, bus.RFWriteEnable, bus.RFSelect, bus.Halted, bus.ALUSelect, bus.DAddr,
             bus.WriteAddr, bus.ReadAddrA, bus.ReadAddrB} !== '0) begin
            n_fail++;
            $display("FAIL rst_ctrl: DW=%b WE=%b SEL=%b H=%b ALU=%0d DA=%0d WA=%0d RA=%0d RB=%0d want all 0",
                     bus.DWrite, bus.RFWriteEnable, bus.RFSelect, bus.Halted, bus.ALUSelect,
                     bus.DAddr, bus.WriteAddr, bus.ReadAddrA, bus.ReadAddrB);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.StateOut !== exp_st[i]) begin n_fail++; $display("FAIL noop_seq[%0d]: state %0d want %0d", i, bus.StateOut, exp_st[i]); end
            if (i == 1) begin
                n_checks++; if (bus.PCOut !== 7'd1) begin n_fail++; $display("FAIL noop_pc: got %0d want 1", bus.PCOut); end
            end
        end
    endtask

    task automatic test_load();
        fill_rom(16'h5000);
        rom[0]   = 16'h2000;
        dinit[0] = 16'd5;
        apply_reset(2);
        rst = 1'b0;
        repeat (3) step();
        n_checks++; if (bus.StateOut !== 4'd4) begin n_fail++; $display("FAIL loada_state: got %0d want 4", bus.StateOut); end
        n_checks++;
        if (bus.DAddr !== 8'd0 || bus.RFSelect !== 1'b1 || bus.RFWriteEnable !== 1'b0 || bus.DWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL loada_ctrl: DA=%0d SEL=%b WE=%b DW=%b want 0/1/0/0", bus.DAddr, bus.RFSelect, bus.RFWriteEnable, bus.DWrite);
        end
        step();
        n_checks++; if (bus.StateOut !== 4'd5) begin n_fail++; $display("FAIL loadb_state: got %0d want 5", bus.StateOut); end
        n_checks++;
        if (bus.RFWriteEnable !== 1'b1 || bus.WriteAddr !== 4'd0 || bus.RFSelect !== 1'b1 || bus.DWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL loadb_ctrl: WE=%b WA=%0d SEL=%b DW=%b want 1/0/1/0", bus.RFWriteEnable, bus.WriteAddr, bus.RFSelect, bus.DWrite);
        end
        step();
        n_checks++; if (bus.StateOut !== 4'd1) begin n_fail++; $display("FAIL load_next: state %0d want 1", bus.StateOut); end
        n_checks++; if (rf[0] !== 16'd5) begin n_fail++; $display("FAIL load_rf0: got %0d want 5", rf[0]); end
    endtask

    task automatic test_program(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] exp_r3, input logic [15:0] exp_d9);
        int cycles;
        load_program(a, b);
        apply_reset(2);
        rst = 1'b0;
        run_to_halt(cycles);
        n_checks++; if (cycles !== 20) begin n_fail++; $display("FAIL prog_latency: %0d cycles want 20", cycles); end
        n_checks++; if (dmem[9] !== exp_d9) begin n_fail++; $display("FAIL prog_d9: got %h want %h", dmem[9], exp_d9); end
        n_checks++; if (rf[3] !== exp_r3) begin n_fail++; $display("FAIL prog_r3: got %h want %h", rf[3], exp_r3); end
        n_checks++; if (rf[2] !== 16'd10) begin n_fail++; $display("FAIL prog_r2: got %h want 000a", rf[2]); end
        n_checks++;
        if (store_seen !== 1'b1 || store_daddr !== 8'd9 || store_ra !== 4'd2) begin
            n_fail++;
            $display("FAIL prog_store: DW=%b DA=%0d RA=%0d want 1/9/2", store_seen, store_daddr, store_ra);
        end
        n_checks++; if (add_alu !== 3'b001) begin n_fail++; $display("FAIL prog_add_alu: got %b want 001", add_alu); end
        n_checks++; if (sub_alu !== 3'b010) begin n_fail++; $display("FAIL prog_sub_alu: got %b want 010", sub_alu); end
        n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL prog_overlap: %0d cycles with DW and WE, want 0", overlap_cnt); end
        repeat (3) step();
        n_checks++;
        if (bus.StateOut !== 4'd9 || bus.Halted !== 1'b1 || bus.PCOut !== 7'd6 || bus.IROut !== 16'h5000) begin
            n_fail++;
            $display("FAIL halt_frozen: st=%0d H=%b PC=%0d IR=%h want 9/1/6/5000", bus.StateOut, bus.Halted, bus.PCOut, bus.IROut);
        end
        n_checks++;
        if (bus.DWrite !== 1'b0 || bus.RFWriteEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enables: DW=%b WE=%b want 0/0", bus.DWrite, bus.RFWriteEnable);
        end
    endtask

    task automatic test_undefined();
        fill_rom(16'h5000);
        rom[0] = 16'hF123;
        apply_reset(2);
        rst = 1'b0;
        repeat (3) step();
        n_checks++; if (bus.StateOut !== 4'd3) begin n_fail++; $display("FAIL undef_state: got %0d want 3", bus.StateOut); end
        n_checks++;
        if (bus.DWrite !== 1'b0 || bus.RFWriteEnable !== 1'b0 || bus.PCOut !== 7'd1 || bus.IROut !== 16'hF123) begin
            n_fail++;
            $display("FAIL undef_ctrl: DW=%b WE=%b PC=%0d IR=%h want 0/0/1/f123", bus.DWrite, bus.RFWriteEnable, bus.PCOut, bus.IROut);
        end
        repeat (3) step();
        n_checks++;
        if (bus.StateOut !== 4'd9 || bus.PCOut !== 7'd2) begin
            n_fail++;
            $display("FAIL undef_next: st=%0d PC=%0d want 9/2", bus.StateOut, bus.PCOut);
        end
    endtask

    task automatic test_pc_wrap();
        fill_rom(16'h0000);
        apply_reset(2);
        rst = 1'b0;
        repeat (1 + 127 * 3) step();
        n_checks++;
        if (bus.StateOut !== 4'd1 || bus.PCOut !== 7'd127) begin
            n_fail++;
            $display("FAIL wrap_pre: st=%0d PC=%0d want 1/127", bus.StateOut, bus.PCOut);
        end
        step();
        n_checks++;
        if (bus.StateOut !== 4'd2 || bus.PCOut !== 7'd0) begin
            n_fail++;
            $display("FAIL wrap_post: st=%0d PC=%0d want 2/0", bus.StateOut, bus.PCOut);
        end
    endtask

    task automatic check_after_reset(input string tag);
        n_checks++;
        if (bus.StateOut !== 4'd0 || bus.PCOut !== 7'd0 || bus.Halted !== 1'b0 ||
            bus.RFWriteEnable !== 1'b0 || bus.IROut !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s: st=%0d PC=%0d H=%b WE=%b IR=%h want 0/0/0/0/0000",
                     tag, bus.StateOut, bus.PCOut, bus.Halted, bus.RFWriteEnable, bus.IROut);
        end
        rst = 1'b0;
        repeat (2) step();
        n_checks++;
        if (bus.StateOut !== 4'd2 || bus.IROut !== 16'h2000 || bus.PCOut !== 7'd1) begin
            n_fail++;
            $display("FAIL %s_restart: st=%0d IR=%h PC=%0d want 2/2000/1", tag, bus.StateOut, bus.IROut, bus.PCOut);
        end
    endtask

    task automatic test_reset_midway();
        int cycles;
        load_program(16'd7, 16'd3);
        apply_reset(2);
        rst = 1'b0;
        cycles = 0;
        while (bus.StateOut !== 4'd5 && cycles < 50) begin
            step();
            cycles++;
        end
        n_checks++; if (bus.StateOut !== 4'd5) begin n_fail++; $display("FAIL reach_loadb: st=%0d want 5", bus.StateOut); end
        rst = 1'b1;
        step();
        check_after_reset("rst_loadb");
        run_to_halt(cycles);
        rst = 1'b1;
        step();
        check_after_reset("rst_halt");
    endtask

    initial begin
        test_reset();
        test_load();
        test_program(16'd7, 16'd3, 16'd4, 16'd10);
        test_program(16'd3, 16'd7, 16'hFFFC, 16'd10);
        test_undefined();
        test_pc_wrap();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
